// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: pipeline entry layout and liveness helper.
package fwd_pkg;
    localparam int REG_W   = 5;
    localparam int SB_XLEN = 32;

    typedef struct packed {
        logic               valid;
        logic               we;
        logic               is_load;
        logic               ready;
        logic [REG_W-1:0]   rd;
        logic [SB_XLEN-1:0] data;
    } sb_entry_t;

    // Only entries that will really write a non-x0 register may forward or retire.
    function automatic logic is_live(sb_entry_t e);
        return e.valid && e.we && (e.rd != '0);
    endfunction
endpackage

// File: rtl/fwd_scoreboard_if.sv
// Producer/consumer/writeback bundle between the core pipeline and fwd_scoreboard.
interface fwd_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 2
);
    import fwd_pkg::*;

    logic                             hold;
    logic                             ex_valid;
    logic                             ex_we;
    logic                             ex_is_load;
    logic [REG_W-1:0]                 ex_rd;
    logic [XLEN-1:0]                  ex_result;
    logic [XLEN-1:0]                  mem_rdata;
    logic [NSRC-1:0][REG_W-1:0]       cons_rs;
    logic [NSRC-1:0]                  cons_used;
    logic [NSRC-1:0]                  fwd_hit;
    logic [NSRC-1:0][XLEN-1:0]        fwd_data;
    logic                             stall;
    logic                             wb_en;
    logic [REG_W-1:0]                 wb_rd;
    logic [XLEN-1:0]                  wb_data;
    logic [31:0]                      stall_cnt;
    logic [31:0]                      fwd_cnt;

    modport master (
        output hold, ex_valid, ex_we, ex_is_load, ex_rd, ex_result, mem_rdata,
               cons_rs, cons_used,
        input  fwd_hit, fwd_data, stall, wb_en, wb_rd, wb_data, stall_cnt, fwd_cnt
    );

    modport slave (
        input  hold, ex_valid, ex_we, ex_is_load, ex_rd, ex_result, mem_rdata,
               cons_rs, cons_used,
        output fwd_hit, fwd_data, stall, wb_en, wb_rd, wb_data, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// One consumer source: youngest-first priority search over the tracked writeback stages.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [REG_W-1:0]      rs,
    input  logic                  used,
    output logic                  hit,
    output logic [XLEN-1:0]       data,
    output logic                  unready
);
    logic found;

    // The first live match decides; an older ready copy must not mask a younger pending load.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        unready = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && used && is_live(entries[k]) && entries[k].rd == rs) begin
                found = 1'b1;
                if (entries[k].ready) begin
                    hit  = 1'b1;
                    data = entries[k].data[XLEN-1:0];
                end else begin
                    unready = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// Result forwarding and load-use interlock over DEPTH (>=2) post-EX stages; XLEN <= SB_XLEN.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = 2,
    parameter int NSRC  = 2
) (
    input logic             clk,
    input logic             rst_n,
    fwd_scoreboard_if.slave bus
);
    sb_entry_t [DEPTH-1:0]     q;
    logic [NSRC-1:0]           hit_w;
    logic [NSRC-1:0][XLEN-1:0] data_w;
    logic [NSRC-1:0]           unready;
    logic                      stall;
    logic                      wb_live;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH)) u_match (
            .entries (q),
            .rs      (bus.cons_rs[s]),
            .used    (bus.cons_used[s]),
            .hit     (hit_w[s]),
            .data    (data_w[s]),
            .unready (unready[s])
        );
    end

    assign stall        = |unready;
    assign bus.stall    = stall;
    assign bus.fwd_hit  = hit_w;
    assign bus.fwd_data = data_w;

    always_comb begin
        wb_live     = is_live(q[DEPTH-1]);
        bus.wb_en   = wb_live && !bus.hold;
        bus.wb_rd   = wb_live ? q[DEPTH-1].rd : '0;
        bus.wb_data = wb_live ? q[DEPTH-1].data[XLEN-1:0] : '0;
    end

    // A stalled consumer enters as a bubble; a load picks up its memory data on the way to stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!bus.hold) begin
            q[0] <= '{valid:   bus.ex_valid && !stall,
                      we:      bus.ex_we,
                      is_load: bus.ex_is_load,
                      ready:   !bus.ex_is_load,
                      rd:      bus.ex_rd,
                      data:    bus.ex_is_load ? {SB_XLEN{1'b0}} : SB_XLEN'(bus.ex_result)};
            q[1] <= q[0];
            if (q[0].valid && q[0].is_load) begin
                q[1].data  <= SB_XLEN'(bus.mem_rdata);
                q[1].ready <= 1'b1;
            end
            for (int k = 2; k < DEPTH; k++) q[k] <= q[k-1];
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_q, fwd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else if (!bus.hold) begin
            if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (!stall && |hit_w && fwd_q != '1) fwd_q <= fwd_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.fwd_cnt   = fwd_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.fwd_cnt   = '0;
`endif
endmodule
